// File: rtl/gray_event_counter_bank.sv
// Bank of up/down event counters exported in binary and registered Gray code,
// with a valid/ready snapshot port that can clear a channel (signalled via epoch).
module gray_event_counter_bank #(
   parameter int CH  = 4,
   parameter int W   = 8,
   parameter int SAT = 0,
   localparam int CHW = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [CH-1:0]          inc,
   input  logic [CH-1:0]          dec,
   output logic [CH-1:0][W-1:0]   cnt_bin,
   output logic [CH-1:0][W-1:0]   cnt_gray,
   output logic [CH-1:0]          epoch,
   output logic [CH-1:0]          ovf,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [CHW-1:0]         req_ch,
   input  logic                   req_clr,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [W-1:0]           rsp_data,
   output logic                   rsp_ovf,
   output logic                   dbg_state
);

   typedef enum logic {S_IDLE = 1'b0, S_RESP = 1'b1} state_t;

   localparam logic [W-1:0] MAXV = '1;

   state_t               state_q, state_d;
   logic [CH-1:0][W-1:0] cnt_q, cnt_d;
   logic [CH-1:0][W-1:0] gray_q, gray_d;
   logic [CH-1:0]        epoch_q, epoch_d;
   logic [CH-1:0]        ovf_q, ovf_d;
   logic [W-1:0]         rsp_data_q, rsp_data_d;
   logic                 rsp_ovf_q, rsp_ovf_d;
   logic [W-1:0]         sel_data;
   logic                 sel_ovf;
   logic                 accept;
   logic [CH-1:0]        hit;

   // Handshake: a request transfers on a cycle with req_valid & req_ready, a
   // response on rsp_valid & rsp_ready; both ready/valid come straight from state.
   assign req_ready = (state_q == S_IDLE);
   assign rsp_valid = (state_q == S_RESP);
   assign accept    = (state_q == S_IDLE) && req_valid;

   always_comb begin
      cnt_d    = cnt_q;
      ovf_d    = ovf_q;
      epoch_d  = epoch_q;
      gray_d   = gray_q;
      hit      = '0;
      sel_data = '0;
      sel_ovf  = 1'b0;
      for (int i = 0; i < CH; i++) begin
         if (inc[i] && !dec[i]) begin
            if (cnt_q[i] == MAXV) begin
               ovf_d[i] = 1'b1;
               if (SAT == 0) cnt_d[i] = '0;
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end else if (dec[i] && !inc[i]) begin
            if (cnt_q[i] == '0) begin
               ovf_d[i] = 1'b1;
               if (SAT == 0) cnt_d[i] = MAXV;
            end else begin
               cnt_d[i] = cnt_q[i] - 1'b1;
            end
         end
         hit[i] = accept && (req_ch == CHW'(i));
         if (hit[i]) begin
            sel_data = cnt_d[i];
            sel_ovf  = ovf_d[i];
         end
         // The accept-cycle count lands in the snapshot only; the channel restarts at 0.
         if (hit[i] && req_clr) begin
            cnt_d[i]   = '0;
            ovf_d[i]   = 1'b0;
            epoch_d[i] = ~epoch_q[i];
         end
         gray_d[i] = cnt_d[i] ^ (cnt_d[i] >> 1);
      end
   end

   always_comb begin
      state_d    = state_q;
      rsp_data_d = rsp_data_q;
      rsp_ovf_d  = rsp_ovf_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               state_d    = S_RESP;
               rsp_data_d = sel_data;
               rsp_ovf_d  = sel_ovf;
            end
         end
         S_RESP: begin
            if (rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         gray_q     <= '0;
         epoch_q    <= '0;
         ovf_q      <= '0;
         rsp_data_q <= '0;
         rsp_ovf_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         gray_q     <= gray_d;
         epoch_q    <= epoch_d;
         ovf_q      <= ovf_d;
         rsp_data_q <= rsp_data_d;
         rsp_ovf_q  <= rsp_ovf_d;
      end
   end

   assign cnt_bin   = cnt_q;
   assign cnt_gray  = gray_q;
   assign epoch     = epoch_q;
   assign ovf       = ovf_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_ovf   = rsp_ovf_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_gray_event_counter_bank.sv
// Directed bench for gray_event_counter_bank: a wrap-mode and a saturate-mode
// instance share counting stimulus; snapshot responses are scoreboarded.
module tb_gray_event_counter_bank;

   localparam int CH  = 4;
   localparam int W   = 8;
   localparam int CHW = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst_n;
   logic [CH-1:0]   inc, dec;
   logic            req_valid, req_clr, rsp_ready;
   logic [CHW-1:0]  req_ch;

   logic [CH-1:0][W-1:0] w_cnt, w_gray, s_cnt, s_gray;
   logic [CH-1:0]        w_epoch, w_ovf, s_epoch, s_ovf;
   logic                 w_req_ready, w_rsp_valid, w_rsp_ovf, w_dbg;
   logic                 s_req_ready, s_rsp_valid, s_rsp_ovf, s_dbg;
   logic [W-1:0]         w_rsp_data, s_rsp_data;
   logic                 s_req_valid = 1'b0;

   gray_event_counter_bank #(.CH(CH), .W(W), .SAT(0)) u_wrap (
      .clk(clk), .rst_n(rst_n), .inc(inc), .dec(dec),
      .cnt_bin(w_cnt), .cnt_gray(w_gray), .epoch(w_epoch), .ovf(w_ovf),
      .req_valid(req_valid), .req_ready(w_req_ready), .req_ch(req_ch), .req_clr(req_clr),
      .rsp_valid(w_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(w_rsp_data),
      .rsp_ovf(w_rsp_ovf), .dbg_state(w_dbg)
   );

   gray_event_counter_bank #(.CH(CH), .W(W), .SAT(1)) u_sat (
      .clk(clk), .rst_n(rst_n), .inc(inc), .dec(dec),
      .cnt_bin(s_cnt), .cnt_gray(s_gray), .epoch(s_epoch), .ovf(s_ovf),
      .req_valid(s_req_valid), .req_ready(s_req_ready), .req_ch(req_ch), .req_clr(req_clr),
      .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(s_rsp_data),
      .rsp_ovf(s_rsp_ovf), .dbg_state(s_dbg)
   );

   logic [W:0] exp_q[$];
   logic [W:0] mon_e;
   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Response monitor: a transfer happens at the posedge following this sample.
   always @(negedge clk) begin
      if (rst_n && w_rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rsp_unexpected: got %0d expected none", w_rsp_data);
         end else begin
            mon_e = exp_q.pop_front();
            chk("rsp_data", {24'd0, w_rsp_data}, {24'd0, mon_e[W-1:0]});
            chk("rsp_ovf", {31'd0, w_rsp_ovf}, {31'd0, mon_e[W]});
         end
      end
   end

   logic [W-1:0] prev_gray;

   initial begin
      rst_n = 1'b0; inc = '0; dec = '0;
      req_valid = 1'b0; req_clr = 1'b0; req_ch = '0; rsp_ready = 1'b0;
      step(2);
      chk("rst_cnt", w_cnt, 0);
      chk("rst_gray", w_gray, 0);
      chk("rst_epoch_ovf", {w_epoch, w_ovf}, 0);
      chk("rst_rsp_valid", w_rsp_valid, 0);
      chk("rst_req_ready", w_req_ready, 1);
      chk("rst_rsp_data", w_rsp_data, 0);
      chk("rst_sat_cnt", s_cnt, 0);

      rst_n = 1'b1;
      inc = 4'b0001;
      for (int i = 0; i < 5; i++) begin
         prev_gray = w_gray[0];
         step();
         chk("gray_one_bit", $countones(w_gray[0] ^ prev_gray), 1);
      end
      chk("cnt0_5", w_cnt[0], 5);
      chk("gray0_7", w_gray[0], 7);

      step(5);
      inc = 4'b0001; dec = 4'b0001;
      step(2);
      chk("incdec_hold_wrap", w_cnt[0], 10);
      chk("incdec_hold_sat", s_cnt[0], 10);

      inc = 4'b0100; dec = '0;
      step(9);
      chk("cnt2_9", w_cnt[2], 9);

      inc = 4'b0010;
      step(255);
      chk("cnt1_255_wrap", w_cnt[1], 255);
      chk("cnt1_255_sat", s_cnt[1], 255);
      chk("ovf1_clear_yet", w_ovf[1], 0);
      step();
      chk("wrap_up_cnt", w_cnt[1], 0);
      chk("wrap_up_ovf", w_ovf[1], 1);
      chk("sat_up_cnt", s_cnt[1], 255);
      chk("sat_up_ovf", s_ovf[1], 1);
      inc = '0; dec = 4'b0010;
      step();
      chk("wrap_down_cnt", w_cnt[1], 255);
      chk("wrap_ovf_sticky", w_ovf[1], 1);
      chk("sat_down_cnt", s_cnt[1], 254);

      dec = 4'b1000;
      step();
      chk("wrap_under_cnt", w_cnt[3], 255);
      chk("wrap_under_ovf", w_ovf[3], 1);
      chk("sat_under_cnt", s_cnt[3], 0);
      chk("sat_under_ovf", s_ovf[3], 1);

      // Snapshot ch2 with clear while ch2 increments on the accept cycle.
      dec = '0; inc = 4'b0100;
      req_valid = 1'b1; req_ch = 2'd2; req_clr = 1'b1; rsp_ready = 1'b0;
      exp_q.push_back({1'b0, 8'd10});
      step();
      req_valid = 1'b0; req_clr = 1'b0; inc = 4'b0001;
      chk("clr_cnt2", w_cnt[2], 0);
      chk("clr_gray2", w_gray[2], 0);
      chk("clr_epoch2", w_epoch[2], 1);
      chk("clr_ovf2", w_ovf[2], 0);
      chk("sat_no_req_cnt2", s_cnt[2], 10);
      for (int i = 0; i < 4; i++) begin
         chk("hold_rsp_valid", w_rsp_valid, 1);
         chk("hold_rsp_data", w_rsp_data, 10);
         chk("hold_req_ready", w_req_ready, 0);
         step();
      end
      chk("count_during_resp", w_cnt[0], 14);
      inc = '0; rsp_ready = 1'b1;
      step();
      chk("back_idle_valid", w_rsp_valid, 0);
      chk("back_idle_ready", w_req_ready, 1);

      // Snapshot ch1 without clear.
      req_valid = 1'b1; req_ch = 2'd1; req_clr = 1'b0;
      exp_q.push_back({1'b1, 8'd255});
      step();
      req_valid = 1'b0;
      chk("noclr_cnt1", w_cnt[1], 255);
      chk("noclr_epoch1", w_epoch[1], 0);
      chk("noclr_ovf1", w_ovf[1], 1);
      step();
      chk("idle_after_noclr", w_dbg, 0);

      // Clear ch3 with a decrement on the accept cycle: ovf reported then cleared.
      req_valid = 1'b1; req_ch = 2'd3; req_clr = 1'b1; dec = 4'b1000;
      exp_q.push_back({1'b1, 8'd254});
      step();
      req_valid = 1'b0; req_clr = 1'b0; dec = '0;
      chk("clr_cnt3", w_cnt[3], 0);
      chk("clr_ovf3", w_ovf[3], 0);
      chk("clr_epoch3", w_epoch[3], 1);
      step();

      // Reset while a response is pending drops it.
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_ch = 2'd0; req_clr = 1'b0;
      exp_q.push_back({1'b0, 8'd14});
      step();
      req_valid = 1'b0;
      chk("resp_before_rst", w_rsp_valid, 1);
      rst_n = 1'b0;
      exp_q.delete();
      step();
      chk("rst_resp_valid", w_rsp_valid, 0);
      chk("rst_all_cnt", w_cnt, 0);
      chk("rst_all_epoch_ovf", {w_epoch, w_ovf}, 0);
      chk("rst_all_sat", {s_cnt, s_ovf}, 0);
      rst_n = 1'b1;
      step(2);

      chk("exp_q_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
